giant_mux_arbiter: RTL and testbench
====================================

// Module: giant_mux_arbiter
// PURPOSE
//  Round-robin arbiter that shares the constant/pass-through selection mux among
//  NUM_REQ requesters. Each requester presents a 4-bit selection code; the winner
//  owns the mux Selection lines until it releases them or a hold timeout fires.
//  Sits between the control unit's requesters and the mux Selection input.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  DEFAULT_SEL  0   Selection value driven when no requester owns the mux (0 = pass-through)
//  MAX_SEL      10  highest legal selection code; codes above it are invalid
//  MAX_HOLD     16  cycles an owner may hold the mux (GMUX_ARB_TIMEOUT_EN only), >=1
// PORTS
//  Clk        in   1          rising-edge clock
//  Rst_n      in   1          asynchronous active-low reset
//  Req        in   NUM_REQ    per-requester request, level, held until granted
//  SelReq     in   4*NUM_REQ  code of requester i at [4*i+3:4*i], sampled at arbitration
//  Done       in   NUM_REQ    per-requester release strobe, honoured only from the owner
//  Grant      out  NUM_REQ    one-hot grant, registered
//  Selection  out  4          mux select, registered
//  Owner      out  3          index of the current owner, valid while Busy
//  Busy       out  1          high in HOLD state
//  SelErr     out  1          1-cycle pulse: an invalid code was skipped at arbitration
//  Timeout    out  1          1-cycle pulse: owner forcibly released (GMUX_ARB_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset (async, Rst_n=0): state IDLE, Grant=0, Selection=DEFAULT_SEL, Owner=0,
//   Busy=0, SelErr=0, Timeout=0, RR pointer=0 (requester 0 has highest priority first).
//  FSM: IDLE, HOLD.
//  IDLE: eligible = Req[i] && SelReq[i] <= MAX_SEL. If any eligible: pick the first
//   eligible index starting at the RR pointer, wrapping modulo NUM_REQ. On the next edge:
//   Grant one-hot, Selection = winner's SelReq, Owner = winner, Busy=1, enter HOLD.
//   Req->Grant latency: 1 cycle.
//  Invalid code: a requester with Req=1 and code > MAX_SEL is not eligible; SelErr
//   pulses once in each IDLE cycle where one exists. If only invalid requesters,
//   stay in IDLE and drive DEFAULT_SEL.
//  HOLD: Grant, Selection and Owner frozen; SelReq changes are ignored.
//   Release when Done[Owner]=1 or Req[Owner]=0. On the next edge: Grant=0,
//   Selection=DEFAULT_SEL, Busy=0, RR pointer = Owner+1 (mod NUM_REQ), enter IDLE.
//   At least one IDLE cycle always separates two ownerships (mux settle cycle).
//  Done from a non-owner: ignored. Done while in IDLE: ignored.
//  Simultaneous Done[Owner] and timeout expiry: treated as a normal release, no Timeout pulse.
//  Reset mid-HOLD: Grant drops immediately (async); the requester must re-request.
//  Requests arriving in HOLD wait; no preemption.
// CONFIGURATION
//  GMUX_ARB_TIMEOUT_EN defined: hold counter cleared on entry to HOLD, incremented
//   each HOLD cycle; in the cycle it reaches MAX_HOLD without a release, Timeout
//   pulses and the release is executed exactly as for Done (the owner loses Grant
//   after MAX_HOLD Grant cycles; RR pointer advances past it).
//  Not defined: no counter; Timeout is tied to 0; the owner holds indefinitely.
// TESTING
//  1. Reset only -> Selection=0, Grant=0, Busy=0, SelErr=0 for 5 cycles.
//  2. Req=4'b0010, SelReq[7:4]=5 -> Grant=0010 and Selection=5 one cycle later;
//     Done[1] pulse -> Grant=0, Selection=0 next cycle.
//  3. Req=4'b1111 held, Done pulsed by each owner -> grant order 0,1,2,3,0 with one
//     idle cycle between each.
//  4. Req=4'b0101, SelReq[3:0]=12, SelReq[11:8]=3 -> SelErr pulse, Grant=0100,
//     Selection=3; requester 0 never granted.
//  5. Owner 2 holding, Done=4'b0001 and SelReq[11:8] changed -> Grant, Selection unchanged.
//  6. GMUX_ARB_TIMEOUT_EN, MAX_HOLD=16, Req=0001 with no Done -> Timeout pulse, Grant
//     drops after 16 Grant cycles; regranted after 1 idle cycle if Req still set.

Source files
------------

// File: rtl/giant_mux_arbiter.sv
// Round-robin owner arbiter for the constant/pass-through mux Selection lines.
// Optional hold timeout is enabled by defining GMUX_ARB_TIMEOUT_EN.

module giant_mux_arbiter_lane #(
  parameter int MAX_SEL = 10
) (
  input  logic       req,
  input  logic [3:0] sel,
  output logic       elig,
  output logic       bad
);
  logic legal;
  assign legal = int'(sel) <= MAX_SEL;
  assign elig  = req & legal;
  assign bad   = req & ~legal;
endmodule

module giant_mux_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DEFAULT_SEL = 0,
  parameter int MAX_SEL     = 10,
  parameter int MAX_HOLD    = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [4*NUM_REQ-1:0] SelReq,
  input  logic [NUM_REQ-1:0]   Done,
  output logic [NUM_REQ-1:0]   Grant,
  output logic [3:0]           Selection,
  output logic [2:0]           Owner,
  output logic                 Busy,
  output logic                 SelErr,
  output logic                 Timeout
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] DSEL = 4'(DEFAULT_SEL);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("giant_mux_arbiter: unsupported NUM_REQ/MAX_HOLD");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                    state;
  logic [NUM_REQ-1:0][3:0]   sel_v;
  logic [NUM_REQ-1:0]        elig, bad;
  logic [IW-1:0]             ptr, own, win, nxt_ptr;
  logic                      found, rel, to_hit, drop;

  assign sel_v = SelReq;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    giant_mux_arbiter_lane #(.MAX_SEL(MAX_SEL)) u_lane (
      .req  (Req[i]),
      .sel  (sel_v[i]),
      .elig (elig[i]),
      .bad  (bad[i])
    );
  end

  // First eligible index at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] e, input logic [IW-1:0] p);
    logic [IW:0] r;
    int j;
    r = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(p) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!r[IW] && e[j]) r = {1'b1, IW'(j)};
    end
    return r;
  endfunction

  assign {found, win} = rr_pick(elig, ptr);
  assign rel     = Done[own] | ~Req[own];
  assign nxt_ptr = (own == IW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
  assign Owner   = 3'(own);

`ifdef GMUX_ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  logic [CW-1:0] hold_cnt;
  // A same-cycle Done wins over expiry, so no Timeout pulse then.
  assign to_hit = (hold_cnt == CW'(MAX_HOLD - 1)) & ~rel;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                   hold_cnt <= '0;
    else if (state == IDLE)       hold_cnt <= '0;
    else if (!drop)               hold_cnt <= hold_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign drop = rel | to_hit;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      Grant     <= '0;
      Selection <= DSEL;
      own       <= '0;
      ptr       <= '0;
      Busy      <= 1'b0;
      SelErr    <= 1'b0;
      Timeout   <= 1'b0;
    end else begin
      SelErr  <= 1'b0;
      Timeout <= 1'b0;
      case (state)
        IDLE: begin
          SelErr <= |bad;
          if (found) begin
            state     <= HOLD;
            Grant     <= NUM_REQ'(1) << win;
            Selection <= sel_v[win];
            own       <= win;
            Busy      <= 1'b1;
          end
        end
        HOLD: begin
          // Release always lands in IDLE, giving the mux one settle cycle.
          if (drop) begin
            state     <= IDLE;
            Grant     <= '0;
            Selection <= DSEL;
            Busy      <= 1'b0;
            ptr       <= nxt_ptr;
            Timeout   <= to_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_giant_mux_arbiter.sv
// Scoreboard bench for giant_mux_arbiter: expected grants are queued at stimulus time.
`timescale 1ns/1ps
module tb_giant_mux_arbiter;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [3:0]  Req = '0, Done = '0;
  logic [15:0] SelReq = '0;
  logic [3:0]  Grant, Selection;
  logic [2:0]  Owner;
  logic        Busy, SelErr, Timeout;

  typedef struct packed {logic [3:0] g; logic [3:0] s;} exp_t;
  exp_t sb[$];
  exp_t e;
  int vec = 0, errs = 0;

  giant_mux_arbiter #(.NUM_REQ(4), .DEFAULT_SEL(0), .MAX_SEL(10), .MAX_HOLD(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .SelReq(SelReq), .Done(Done),
    .Grant(Grant), .Selection(Selection), .Owner(Owner), .Busy(Busy),
    .SelErr(SelErr), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset;
    Rst_n = 1'b0; Req = '0; Done = '0; SelReq = '0;
    repeat (2) tick();
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vec++;
      if ({Grant, Selection, Owner, Busy, SelErr, Timeout} !== 14'd0) begin
        errs++;
        $display("FAIL reset_state c=%0d got g=%b s=%0d o=%0d b=%b e=%b t=%b want all 0",
                 c, Grant, Selection, Owner, Busy, SelErr, Timeout);
      end
    end
    Rst_n = 1'b1;
    Done = 4'b1111;
    repeat (2) tick();
    Done = '0;
    vec++;
    if ({Grant, Busy} !== 5'd0) begin
      errs++; $display("FAIL idle_done got g=%b b=%b want 0 0", Grant, Busy);
    end
  endtask

  task automatic test_single;
    do_reset();
    sb.push_back('{4'b0010, 4'd5});
    SelReq[7:4] = 4'd5; Req = 4'b0010;
    tick();
    e = sb.pop_front();
    vec++;
    if ({Grant, Selection} !== {e.g, e.s}) begin
      errs++; $display("FAIL single_grant got %b/%0d want %b/%0d", Grant, Selection, e.g, e.s);
    end
    vec++;
    if ({Owner, Busy} !== {3'd1, 1'b1}) begin
      errs++; $display("FAIL single_owner got o=%0d b=%b want 1 1", Owner, Busy);
    end
    Done = 4'b0010; Req = '0;
    tick();
    Done = '0;
    vec++;
    if ({Grant, Selection, Busy} !== 9'd0) begin
      errs++; $display("FAIL single_release got %b/%0d b=%b want 0000/0 0", Grant, Selection, Busy);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    SelReq = 16'h4321;
    for (int k = 0; k < 5; k++) sb.push_back('{4'(1 << (k % 4)), 4'(k % 4 + 1)});
    Req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      e = sb.pop_front();
      vec++;
      if ({Grant, Selection} !== {e.g, e.s}) begin
        errs++; $display("FAIL rr_grant k=%0d got %b/%0d want %b/%0d", k, Grant, Selection, e.g, e.s);
      end
      Done = e.g;
      if (k == 4) Req = '0;
      tick();
      Done = '0;
      vec++;
      if ({Grant, Busy} !== 5'd0) begin
        errs++; $display("FAIL rr_idle k=%0d got g=%b b=%b want 0 0", k, Grant, Busy);
      end
      tick();
    end
  endtask

  task automatic test_invalid;
    do_reset();
    SelReq[3:0] = 4'd12; SelReq[11:8] = 4'd3;
    sb.push_back('{4'b0100, 4'd3});
    Req = 4'b0101;
    tick();
    e = sb.pop_front();
    vec++;
    if ({Grant, Selection, SelErr} !== {e.g, e.s, 1'b1}) begin
      errs++; $display("FAIL inv_grant got %b/%0d err=%b want %b/%0d err=1", Grant, Selection, SelErr, e.g, e.s);
    end
    tick();
    vec++;
    if (SelErr !== 1'b0) begin
      errs++; $display("FAIL inv_hold_err got %b want 0", SelErr);
    end
    Req = 4'b0001;
    tick();
    vec++;
    if ({Grant, Selection} !== 8'd0) begin
      errs++; $display("FAIL inv_reqdrop got %b/%0d want 0000/0", Grant, Selection);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vec++;
      if ({Grant, Selection, Busy, SelErr} !== 10'b1) begin
        errs++; $display("FAIL inv_only c=%0d got g=%b s=%0d b=%b err=%b want 0 0 0 1",
                         c, Grant, Selection, Busy, SelErr);
      end
    end
    Req = '0;
    tick();
  endtask

  task automatic test_hold_ignore;
    do_reset();
    SelReq[11:8] = 4'd7; SelReq[3:0] = 4'd2;
    sb.push_back('{4'b0100, 4'd7});
    Req = 4'b0100;
    tick();
    e = sb.pop_front();
    vec++;
    if ({Grant, Selection} !== {e.g, e.s}) begin
      errs++; $display("FAIL hold_grant got %b/%0d want %b/%0d", Grant, Selection, e.g, e.s);
    end
    Req = 4'b0101; Done = 4'b0001; SelReq[11:8] = 4'd9;
    for (int c = 0; c < 3; c++) begin
      tick();
      vec++;
      if ({Grant, Selection, Owner} !== {4'b0100, 4'd7, 3'd2}) begin
        errs++; $display("FAIL hold_frozen c=%0d got %b/%0d o=%0d want 0100/7 o=2", c, Grant, Selection, Owner);
      end
    end
    Done = 4'b0100;
    tick();
    Done = '0;
    vec++;
    if (Grant !== 4'b0000) begin
      errs++; $display("FAIL hold_release got %b want 0000", Grant);
    end
    sb.push_back('{4'b0001, 4'd2});
    tick();
    e = sb.pop_front();
    vec++;
    if ({Grant, Selection} !== {e.g, e.s}) begin
      errs++; $display("FAIL rr_wrap got %b/%0d want %b/%0d", Grant, Selection, e.g, e.s);
    end
    Rst_n = 1'b0;
    #1;
    vec++;
    if ({Grant, Busy} !== 5'd0) begin
      errs++; $display("FAIL async_reset got g=%b b=%b want 0 0", Grant, Busy);
    end
    Req = '0;
    #1 Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    SelReq[3:0] = 4'd6;
    Req = 4'b0001;
`ifdef GMUX_ARB_TIMEOUT_EN
    sb.push_back('{4'b0001, 4'd6});
    sb.push_back('{4'b0001, 4'd6});
    tick();
    e = sb.pop_front();
    vec++;
    if ({Grant, Selection} !== {e.g, e.s}) begin
      errs++; $display("FAIL to_grant got %b/%0d want %b/%0d", Grant, Selection, e.g, e.s);
    end
    n = 1;
    while (n < 100) begin
      tick();
      if (Grant !== 4'b0001) break;
      n++;
    end
    vec++;
    if (n !== 16) begin
      errs++; $display("FAIL to_cycles got %0d want 16", n);
    end
    vec++;
    if ({Grant, Timeout} !== 5'b00001) begin
      errs++; $display("FAIL to_pulse got g=%b t=%b want 0000 1", Grant, Timeout);
    end
    tick();
    e = sb.pop_front();
    vec++;
    if ({Grant, Selection, Timeout} !== {e.g, e.s, 1'b0}) begin
      errs++; $display("FAIL to_regrant got %b/%0d t=%b want %b/%0d t=0", Grant, Selection, Timeout, e.g, e.s);
    end
`else
    n = 0;
    repeat (40) begin
      tick();
      if (Grant !== 4'b0001 || Timeout !== 1'b0) n++;
    end
    vec++;
    if (n !== 0) begin
      errs++; $display("FAIL no_timeout bad_cycles got %0d want 0 (g=%b t=%b)", n, Grant, Timeout);
    end
`endif
    Req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_invalid();
    test_hold_ignore();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
